branch_resolve_ctrl: RTL

Execute-stage controller that sequences the shared branch comparator for one branch or jump at a time. It accepts a resolved-operand request from decode, drives the comparator, computes the actual next PC, and compares it against decode's predicted PC. It then issues a one-cycle resolve/redirect/flush to the fetch/pipeline control logic and keeps saturating branch and mispredict counters for the performance CSRs.

---
 rtl/branch_resolve_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolver: drives the shared comparator, computes the
// real next PC, issues a one-cycle resolve/redirect pulse, and counts branches.
module branch_resolve_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_pc_i,
  input  logic [31:0] req_imm_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [2:0]  req_funct3_i,
  input  logic        req_is_jal_i,
  input  logic        req_is_jalr_i,
  input  logic [31:0] req_pred_pc_i,
  input  logic        kill_i,
  output logic [31:0] cmp_in1_o,
  output logic [31:0] cmp_in2_o,
  output logic [2:0]  cmp_op_o,
  input  logic        cmp_taken_i,
  output logic        resolve_valid_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        link_valid_o,
  output logic [31:0] link_data_o,
  output logic        misalign_exc_o,
  output logic [31:0] br_count_o,
  output logic [31:0] mispred_count_o
);

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, imm_q, imm_d, pred_q, pred_d;
  logic        jal_q, jal_d, jalr_q, jalr_d;
  logic [31:0] cmp_in1_q, cmp_in1_d, cmp_in2_q, cmp_in2_d;
  logic [2:0]  cmp_op_q, cmp_op_d;
  logic        resolve_q, resolve_d, redirect_q, redirect_d;
  logic        link_valid_q, link_valid_d, misalign_q, misalign_d;
  logic [31:0] redirect_pc_q, redirect_pc_d, link_data_q, link_data_d;
  logic [31:0] br_q, br_d, mispred_q, mispred_d;

  logic        taken, misalign, mispredict;
  logic [31:0] sum_base, sum, target, seq_pc, actual;

  // The captured rs1/rs2/funct3 live directly in the comparator operand
  // registers, so they are stable through EVAL and hold afterwards.
  assign taken      = jal_q | jalr_q | cmp_taken_i;
  assign sum_base   = jalr_q ? cmp_in1_q : pc_q;
  assign sum        = sum_base + imm_q;
  assign target     = jalr_q ? {sum[31:1], 1'b0} : sum;
  assign seq_pc     = pc_q + 32'd4;
  assign actual     = taken ? target : seq_pc;
  assign misalign   = taken & target[1];
  assign mispredict = ~misalign & (actual != pred_q);

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    pc_d          = pc_q;
    imm_d         = imm_q;
    pred_d        = pred_q;
    jal_d         = jal_q;
    jalr_d        = jalr_q;
    cmp_in1_d     = cmp_in1_q;
    cmp_in2_d     = cmp_in2_q;
    cmp_op_d      = cmp_op_q;
    resolve_d     = 1'b0;
    redirect_d    = 1'b0;
    link_valid_d  = 1'b0;
    misalign_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    link_data_d   = link_data_q;
    br_d          = br_q;
    mispred_d     = mispred_q;
    case (state_q)
      IDLE: begin
        req_ready_o = ~kill_i;
        if (req_valid_i && !kill_i) begin
          pc_d      = req_pc_i;
          imm_d     = req_imm_i;
          pred_d    = req_pred_pc_i;
          jal_d     = req_is_jal_i;
          jalr_d    = req_is_jalr_i;
          cmp_in1_d = req_rs1_i;
          cmp_in2_d = req_rs2_i;
          cmp_op_d  = req_funct3_i;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          state_d       = RESOLVE;
          resolve_d     = 1'b1;
          redirect_d    = mispredict;
          redirect_pc_d = actual;
          link_valid_d  = jal_q | jalr_q;
          link_data_d   = seq_pc;
          misalign_d    = misalign;
          br_d          = (br_q == 32'hFFFF_FFFF) ? br_q : br_q + 32'd1;
          if (mispredict && mispred_q != 32'hFFFF_FFFF) begin
            mispred_d = mispred_q + 32'd1;
          end
        end
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      imm_q         <= '0;
      pred_q        <= '0;
      jal_q         <= 1'b0;
      jalr_q        <= 1'b0;
      cmp_in1_q     <= '0;
      cmp_in2_q     <= '0;
      cmp_op_q      <= '0;
      resolve_q     <= 1'b0;
      redirect_q    <= 1'b0;
      link_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_data_q   <= '0;
      br_q          <= '0;
      mispred_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      pred_q        <= pred_d;
      jal_q         <= jal_d;
      jalr_q        <= jalr_d;
      cmp_in1_q     <= cmp_in1_d;
      cmp_in2_q     <= cmp_in2_d;
      cmp_op_q      <= cmp_op_d;
      resolve_q     <= resolve_d;
      redirect_q    <= redirect_d;
      link_valid_q  <= link_valid_d;
      misalign_q    <= misalign_d;
      redirect_pc_q <= redirect_pc_d;
      link_data_q   <= link_data_d;
      br_q          <= br_d;
      mispred_q     <= mispred_d;
    end
  end

  assign cmp_in1_o        = cmp_in1_q;
  assign cmp_in2_o        = cmp_in2_q;
  assign cmp_op_o         = cmp_op_q;
  assign resolve_valid_o  = resolve_q;
  assign redirect_valid_o = redirect_q;
  assign flush_o          = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign link_valid_o     = link_valid_q;
  assign link_data_o      = link_data_q;
  assign misalign_exc_o   = misalign_q;
  assign br_count_o       = br_q;
  assign mispred_count_o  = mispred_q;

endmodule
